// File: rtl/ahb_fir_pkg.sv
// ahb_fir_pkg: shared types and sizing for the FIR subsystem AHB-Lite fabric.
// Holds the master count, the master index width, and the HTRANS and arbiter state types.
package ahb_fir_pkg;

  localparam int NUM_M        = 2;
  localparam int M_ADDR_WIDTH = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic {
    PARK  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Ports: req (request vector), start (first index searched), idx (winner), valid (any request).
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         valid
);

  int k;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB-Lite arbiter with lock, parking and data-phase owner tracking.
// Ports: clk, rst_n (sync, active low), hbusreq, hlock, htrans_m, hready in;
//        hgrant, hmaster, hmaster_data, hmastlock out. Macro ARB_TIMEOUT_EN adds a hold limit.
module ahb_arbiter #(
  parameter int NUM_M          = ahb_fir_pkg::NUM_M,
  parameter int M_ADDR_WIDTH   = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_M-1:0]             hbusreq,
  input  logic [NUM_M-1:0]             hlock,
  input  logic [NUM_M-1:0][1:0]        htrans_m,
  input  logic                         hready,
  output logic [NUM_M-1:0]             hgrant,
  output logic [M_ADDR_WIDTH-1:0]      hmaster,
  output logic [M_ADDR_WIDTH-1:0]      hmaster_data,
  output logic                         hmastlock
);

  import ahb_fir_pkg::*;

  localparam logic [M_ADDR_WIDTH-1:0] DEF =
    M_ADDR_WIDTH'(DEFAULT_MASTER);

  arb_state_t              state_q, state_d;
  logic [M_ADDR_WIDTH-1:0] mst_q, mst_d;
  logic [M_ADDR_WIDTH-1:0] dmst_q, dmst_d;
  logic [NUM_M-1:0]        gnt_q, gnt_d;
  logic                    lock_q, lock_d;

  logic [M_ADDR_WIDTH-1:0] start;
  logic [M_ADDR_WIDTH-1:0] win;
  logic                    win_vld;
  logic                    own_req;
  logic                    own_lock;
  logic                    expire;
  logic                    arb;

  // Search begins just past the owner so the owner is always tried last.
  always_comb begin
    if (int'(mst_q) + 1 >= NUM_M) start = '0;
    else                          start = mst_q + 1'b1;
  end

  rr_pick #(
    .N (NUM_M),
    .W (M_ADDR_WIDTH)
  ) u_pick (
    .req   (hbusreq),
    .start (start),
    .idx   (win),
    .valid (win_vld)
  );

  assign own_req  = hbusreq[mst_q];
  assign own_lock = own_req & hlock[mst_q];

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1) + 1;

  logic [HW-1:0]    hold_q, hold_d;
  logic [NUM_M-1:0] others;
  htrans_t          own_tr;

  assign others = hbusreq & ~(NUM_M'(1) << mst_q);
  assign own_tr = htrans_t'(htrans_m[mst_q]);

  // Preempt only on a transfer boundary and never inside a locked sequence.
  assign expire = (state_q == OWNED)
               && (int'(hold_q) >= MAX_HOLD - 1)
               && (|others)
               && ((own_tr == IDLE) || (own_tr == NONSEQ))
               && !hlock[mst_q];

  always_comb begin
    hold_d = hold_q;
    if (hready) begin
      if (state_d == PARK || mst_d != mst_q || state_q == PARK)
        hold_d = '0;
      else if (hold_q != '1)
        hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  logic unused_cfg;

  assign expire     = 1'b0;
  assign unused_cfg = ^{htrans_m, 32'(MAX_HOLD)};
`endif

  assign arb = hready && !own_lock
            && (!own_req || state_q == PARK || expire);

  always_comb begin
    state_d = state_q;
    mst_d   = mst_q;
    dmst_d  = dmst_q;
    gnt_d   = gnt_q;
    lock_d  = lock_q;
    if (hready) begin
      if (arb) begin
        unique case (1'b1)
          win_vld: begin
            state_d = OWNED;
            mst_d   = win;
          end
          default: begin
            state_d = PARK;
            mst_d   = DEF;
          end
        endcase
      end
      gnt_d  = NUM_M'(1) << mst_d;
      dmst_d = mst_q;
      lock_d = hlock[mst_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PARK;
      mst_q   <= DEF;
      dmst_q  <= DEF;
      gnt_q   <= NUM_M'(1) << DEF;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mst_q   <= mst_d;
      dmst_q  <= dmst_d;
      gnt_q   <= gnt_d;
      lock_q  <= lock_d;
    end
  end

  assign hgrant       = gnt_q;
  assign hmaster      = mst_q;
  assign hmaster_data = dmst_q;
  assign hmastlock    = lock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed bench for ahb_arbiter with a cycle-level reference model.
// Honours ARB_TIMEOUT_EN the same way the design does.
module tb_ahb_arbiter;

  localparam int N   = 2;
  localparam int DEF = 0;
  localparam int MH  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    hbusreq;
  logic [N-1:0]    hlock;
  logic [N-1:0][1:0] htrans_m;
  logic            hready;
  logic [N-1:0]    hgrant;
  logic [0:0]      hmaster;
  logic [0:0]      hmaster_data;
  logic            hmastlock;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans_m     (htrans_m),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index, parked flag, hold count, data owner, lock.
  int m_own, m_data, m_hold;
  bit m_park, m_lock, m_live;
  int t_nxt, t_hold;
  bit t_park, t_arb, t_to, t_oth, t_found;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_own  <= DEF;
      m_data <= DEF;
      m_park <= 1'b1;
      m_lock <= 1'b0;
      m_hold <= 0;
      m_live <= 1'b1;
    end else if (hready) begin
      t_oth = 1'b0;
      for (int j = 0; j < N; j++)
        if (j != m_own && hbusreq[j]) t_oth = 1'b1;
      t_to = 1'b0;
`ifdef ARB_TIMEOUT_EN
      t_to = !m_park && m_hold >= MH - 1 && t_oth && !hlock[m_own]
          && (htrans_m[m_own] == 2'd0 || htrans_m[m_own] == 2'd2);
`endif
      t_arb = !(hlock[m_own] && hbusreq[m_own])
           && (!hbusreq[m_own] || m_park || t_to);
      t_nxt  = m_own;
      t_park = m_park;
      if (t_arb) begin
        t_found = 1'b0;
        for (int i = 1; i <= N; i++)
          if (!t_found && hbusreq[(m_own + i) % N]) begin
            t_found = 1'b1;
            t_nxt   = (m_own + i) % N;
          end
        t_park = !t_found;
        if (!t_found) t_nxt = DEF;
      end
      if (t_park || t_nxt != m_own || m_park) t_hold = 0;
      else                                    t_hold = m_hold + 1;
      m_data <= m_own;
      m_own  <= t_nxt;
      m_park <= t_park;
      m_hold <= t_hold;
      m_lock <= hlock[t_nxt];
    end
  end

  // Every cycle after the first edge the outputs must match the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("hgrant",       int'(hgrant),       1 << m_own);
      chk("hmaster",      int'(hmaster),      m_own);
      chk("hmaster_data", int'(hmaster_data), m_data);
      chk("hmastlock",    int'(hmastlock),    int'(m_lock));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_live   = 1'b0;
    rst_n    = 1'b0;
    hbusreq  = 2'b11;
    hlock    = 2'b00;
    htrans_m = '0;
    hready   = 1'b1;
    step(2);
    chk("rst_grant", int'(hgrant), 1);
    chk("rst_mst",   int'(hmaster), 0);
    chk("rst_data",  int'(hmaster_data), 0);
    chk("rst_lock",  int'(hmastlock), 0);

    // Release with both requesting: search from 1 picks master 1.
    rst_n = 1'b1;
    step(1);
    chk("rel_grant", int'(hgrant), 2);
    hbusreq = 2'b00;
    step(1);
    chk("park_grant", int'(hgrant), 1);

    // Single request from PARK.
    hbusreq = 2'b10;
    step(1);
    chk("single_grant", int'(hgrant), 2);
    chk("single_mst",   int'(hmaster), 1);
    step(1);
    chk("single_data",  int'(hmaster_data), 1);

    // Round-robin handoffs.
    hbusreq = 2'b01;
    step(1);
    chk("rr_to0", int'(hmaster), 0);
    hbusreq = 2'b11;
    step(3);
    chk("rr_hold0", int'(hmaster), 0);
    hbusreq = 2'b10;
    step(1);
    chk("rr_to1", int'(hmaster), 1);
    hbusreq = 2'b11;
    step(1);
    chk("rr_keep1", int'(hmaster), 1);
    hbusreq = 2'b01;
    step(1);
    chk("rr_back0", int'(hmaster), 0);

    // Wait states freeze everything.
    hbusreq = 2'b10;
    step(2);
    hready  = 1'b0;
    hbusreq = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("ws_grant", int'(hgrant), 2);
      chk("ws_data",  int'(hmaster_data), 1);
    end
    hready = 1'b1;
    step(1);
    chk("ws_switch", int'(hgrant), 1);
    chk("ws_dlag",   int'(hmaster_data), 1);

    // Locked sequence by master 0 against a persistent master 1.
    htrans_m[0] = 2'd2;
    hlock   = 2'b01;
    hbusreq = 2'b11;
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk("lk_grant", int'(hgrant), 1);
      chk("lk_lock",  int'(hmastlock), 1);
    end
    hlock = 2'b00;
    step(1);
`ifdef ARB_TIMEOUT_EN
    chk("lk_release", int'(hgrant), 2);
`else
    chk("lk_release", int'(hgrant), 1);
`endif
    chk("lk_unlock", int'(hmastlock), 0);

    // Hold limit: master 0 owns, master 1 requests from the first owned cycle.
    hbusreq = 2'b00;
    step(1);
    hbusreq = 2'b01;
    step(1);
    chk("to_own0", int'(hmaster), 0);
    hbusreq = 2'b11;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      chk("to_keep", int'(hmaster), 0);
    end
    step(1);
`ifdef ARB_TIMEOUT_EN
    chk("to_16th", int'(hmaster), 1);
`else
    chk("to_16th", int'(hmaster), 0);
    step(30);
    chk("to_never", int'(hmaster), 0);
`endif

    // Reset mid-burst drops ownership.
    hbusreq = 2'b10;
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_grant", int'(hgrant), 1);
    chk("mid_rst_data",  int'(hmaster_data), 0);
    rst_n = 1'b1;
    step(2);
    chk("post_rst", int'(hmaster), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Multi-master AHB-Lite arbiter placed in front of the address decoder and slave read mux of the FIR subsystem.
- Shares the single AHB-Lite fabric between NUM_M requesters, for example a CPU port and a FIR coefficient/sample DMA.
- Issues a one-hot grant and the address-phase owner index.
- Issues a registered data-phase owner index, advanced on hready, so the master-side return paths route correctly.

Parameters:
- NUM_M, 2, number of requesting masters (2..8).
- M_ADDR_WIDTH, $clog2(NUM_M), width of master index.
- DEFAULT_MASTER, 0, master parked on when nobody requests.
- MAX_HOLD, 16, grant-hold limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- hbusreq  input  NUM_M  per-master bus request; held through the last address phase of a burst
- hlock  input  NUM_M  per-master locked-sequence request
- htrans_m  input  NUM_M x 2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- hready  input  1  bus HREADY from the slave mux
- hgrant  output  NUM_M  one-hot grant, registered
- hmaster  output  M_ADDR_WIDTH  address-phase owner index, registered
- hmaster_data  output  M_ADDR_WIDTH  data-phase owner index, registered
- hmastlock  output  1  current owner holds a locked sequence

Behaviour:
- Reset (rst_n low, sampled on a clk edge):
  - hgrant = one-hot(DEFAULT_MASTER).
  - hmaster = DEFAULT_MASTER.
  - hmaster_data = DEFAULT_MASTER.
  - hmastlock = 0.
  - State = PARK; hold counter = 0.
  - A reset asserted mid-burst aborts ownership unconditionally.
- States:
  - PARK: the default master is granted and no request is being served.
  - OWNED: hmaster has an active hbusreq.
- Arbitration point: a clk edge with hready=1 and either
  - hbusreq[hmaster]=0, or
  - in PARK, or
  - a timeout fires (see Optional Feature).
- With hready=0, every output and the state hold.
- Owner selection at an arbitration point:
  - Round-robin search starting at index hmaster+1, modulo NUM_M, wrapping around.
  - The first master with hbusreq=1 wins.
  - The current owner is checked last.
  - If no request, go to PARK on DEFAULT_MASTER.
- Lock:
  - If hlock[hmaster]=1 and hbusreq[hmaster]=1, no arbitration point occurs, including timeout.
  - hmastlock <= hlock[new owner] at every hready-high edge.
- Transitions:
  - PARK to OWNED when any request wins.
  - OWNED to OWNED when the owner changes or keeps its grant.
  - OWNED to PARK when there are no requests.
- Latency:
  - A request sampled at an arbitration point appears on hgrant/hmaster one cycle later.
  - That master's first address phase starts in that cycle.
- Data-phase owner: every hready=1 edge does hmaster_data <= hmaster. hmaster_data lags hmaster by exactly one completed transfer.
- Simultaneous requests from all masters are fair: each master is granted within NUM_M arbitration points.
- Grant is always one-hot; hmaster always equals the index of the grant bit.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter increments each hready-high cycle in OWNED without an owner change.
  - The counter clears on owner change or on PARK.
  - When counter >= MAX_HOLD-1, another master requests, htrans_m[hmaster] is IDLE or NONSEQ, and hlock is inactive, the edge is an arbitration point even if the owner still requests.
  - In that case the owner is considered last in the round-robin order.
- Undefined:
  - No counter is present.
  - An owner keeps the grant until it drops hbusreq.

Decomposition:
- Additions to ahb_fir_pkg:
  - NUM_M.
  - M_ADDR_WIDTH.
  - Typedef htrans_t (enum IDLE/BUSY/NONSEQ/SEQ).
  - Typedef arb_state_t (PARK/OWNED).
- One natural sub-module: rr_pick, a combinational round-robin priority picker. Inputs are the request vector and the start index; outputs are the winner index and a valid flag. It is reusable by other schedulers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with hbusreq=2'b11. Required: hgrant=2'b01, hmaster=0, hmaster_data=0, hmastlock=0; on release, the arbitration rules apply.
- Single request: hbusreq=2'b10 with hready=1 from PARK. Required: next cycle hgrant=2'b10, hmaster=1; one cycle later hmaster_data=1.
- Round-robin: hbusreq=2'b11 held with master 0 owner, then master 0 drops for one cycle and re-requests. Required: grant moves to 1; when 1 drops, grant returns to 0; no master is granted twice in a row while the other waits.
- Wait states: with owner=1, pulse hbusreq[1]=0 while hready=0 for 3 cycles. Required: hgrant, hmaster and hmaster_data stay frozen until the hready=1 edge, then the grant switches.
- Lock: master 0 with hlock=1 and hbusreq=1, master 1 requesting for 40 cycles, ARB_TIMEOUT_EN defined. Required: no grant change until hlock drops; hmastlock=1 throughout.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): master 0 requests continuously with htrans_m[0]=NONSEQ, master 1 requests from cycle 0. Required: grant moves to master 1 on the 16th hready-high owned cycle. Same scenario without the macro: master 0 keeps the grant indefinitely.
